// File: rtl/ov7670_pkg.sv
// Shared types and constants for the OV7670 capture path: the binner FSM
// states, the default bin grid size and the RGB565 field layout.
package ov7670_pkg;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WAIT_FRAME = 2'd1,
    ST_ACTIVE     = 2'd2
  } bin_state_t;

  localparam int COLS_DEF = 32;

  // RGB565 field positions
  localparam int R_MSB = 15;
  localparam int R_LSB = 11;
  localparam int G_MSB = 10;
  localparam int G_LSB = 5;
  localparam int B_MSB = 4;
  localparam int B_LSB = 0;

  // Zero-extended channel extraction, sized for the 16-bit bin sums
  function automatic logic [15:0] px_r(input logic [15:0] p);
    return {11'd0, p[R_MSB:R_LSB]};
  endfunction

  function automatic logic [15:0] px_g(input logic [15:0] p);
    return {10'd0, p[G_MSB:G_LSB]};
  endfunction

  function automatic logic [15:0] px_b(input logic [15:0] p);
    return {11'd0, p[B_MSB:B_LSB]};
  endfunction

endpackage

// File: rtl/bin_counter.sv
// Position tracking for the row binner: pixel-in-line, column via a
// sub-counter (no divider), line-within-bin-row and bin-row index.
// A line_start pulse takes effect in its own cycle, so a pixel arriving
// with it is pixel 0 of the new line.
module bin_counter #(
  parameter int H_PIXELS = 640,
  parameter int V_LINES  = 480,
  parameter int COLS     = 32,
  parameter int COL_W    = $clog2(COLS + 1),
  parameter int ROW_W    = $clog2(COLS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_clr,
  input  logic             i_line_start,
  input  logic             i_pxl_valid,
  output logic             o_accept,
  output logic [COL_W-1:0] o_col,
  output logic             o_row_end,
  output logic             o_frame_end,
  output logic [ROW_W-1:0] o_row
);

  localparam int BIN_W  = H_PIXELS / COLS;
  localparam int BIN_H  = V_LINES / COLS;
  localparam int HC_W   = $clog2(H_PIXELS + 1);
  localparam int SUB_W  = $clog2(BIN_W + 1);
  localparam int LINE_W = $clog2(BIN_H + 1);

  logic [HC_W-1:0]   r_hcnt;
  logic [SUB_W-1:0]  r_sub;
  logic [COL_W-1:0]  r_col;
  logic [LINE_W-1:0] r_line;
  logic [ROW_W-1:0]  r_row;

  logic [HC_W-1:0]  w_hcnt;
  logic [SUB_W-1:0] w_sub;
  logic [COL_W-1:0] w_col;
  logic             w_accept;
  logic             w_line_end;
  logic             w_row_end;

  // Effective position of the current pixel and end-of-line/row detection
  always_comb begin
    w_hcnt     = i_line_start ? '0 : r_hcnt;
    w_sub      = i_line_start ? '0 : r_sub;
    w_col      = i_line_start ? '0 : r_col;
    w_accept   = !i_clr && i_pxl_valid && (w_hcnt < HC_W'(H_PIXELS));
    w_line_end = w_accept && (w_hcnt == HC_W'(H_PIXELS - 1));
    w_row_end  = w_line_end && (r_line == LINE_W'(BIN_H - 1));
  end

  // Counter state; hcnt parks at H_PIXELS so overlong lines are ignored
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hcnt <= '0;
      r_sub  <= '0;
      r_col  <= '0;
      r_line <= '0;
      r_row  <= '0;
    end else if (i_clr) begin
      r_hcnt <= '0;
      r_sub  <= '0;
      r_col  <= '0;
      r_line <= '0;
      r_row  <= '0;
    end else begin
      if (w_accept) begin
        r_hcnt <= w_hcnt + 1'b1;
        if (w_sub == SUB_W'(BIN_W - 1)) begin
          r_sub <= '0;
          r_col <= w_col + 1'b1;
        end else begin
          r_sub <= w_sub + 1'b1;
          r_col <= w_col;
        end
      end else if (i_line_start) begin
        r_hcnt <= '0;
        r_sub  <= '0;
        r_col  <= '0;
      end
      if (w_line_end) begin
        if (w_row_end) begin
          r_line <= '0;
          r_row  <= (r_row == ROW_W'(COLS - 1)) ? '0 : r_row + 1'b1;
        end else begin
          r_line <= r_line + 1'b1;
        end
      end
    end
  end

  assign o_accept    = w_accept;
  assign o_col       = w_col;
  assign o_row_end   = w_row_end;
  assign o_frame_end = w_row_end && (r_row == ROW_W'(COLS - 1));
  assign o_row       = r_row;

endmodule

// File: rtl/pxl_row_binner.sv
// Accumulates RGB565 pixels into COLS horizontal bins per bin row and
// commits each finished bin row into one of two ping-pong banks.
module pxl_row_binner
  import ov7670_pkg::*;
#(
  parameter int H_PIXELS = 640,
  parameter int V_LINES  = 480,
  parameter int COLS     = COLS_DEF
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start_en,
  input  logic                        cont_read,
  input  logic                        frame_start,
  input  logic                        line_start,
  input  logic                        pxl_valid,
  input  logic [15:0]                 pxl_data,
  output logic [1:0][COLS-1:0][15:0]  r_data,
  output logic [1:0][COLS-1:0][15:0]  g_data,
  output logic [1:0][COLS-1:0][15:0]  b_data,
  output logic [5:0]                  row_o,
  output logic                        row_done,
  output logic                        pxl_idle_o
);

  localparam int COL_W = $clog2(COLS + 1);
  localparam int ROW_W = $clog2(COLS);

  bin_state_t r_state;
  bin_state_t w_state_next;

  logic             w_clr;
  logic             w_accept;
  logic [COL_W-1:0] w_col;
  logic             w_row_end;
  logic             w_frame_end;
  logic [ROW_W-1:0] w_row;

  logic [COLS-1:0][15:0] r_acc_r, r_acc_g, r_acc_b;
  logic [COLS-1:0][15:0] w_sum_r, w_sum_g, w_sum_b;
  logic [1:0][COLS-1:0][15:0] r_bank_r, r_bank_g, r_bank_b;
  logic [5:0] r_row_o;
  logic       r_row_done;

  // Counters sit cleared outside ACTIVE; frame_start in ACTIVE restarts them
  assign w_clr = (r_state != ST_ACTIVE) || frame_start;

  bin_counter #(
    .H_PIXELS (H_PIXELS),
    .V_LINES  (V_LINES),
    .COLS     (COLS),
    .COL_W    (COL_W),
    .ROW_W    (ROW_W)
  ) u_cnt (
    .clk          (clk),
    .reset        (reset),
    .i_clr        (w_clr),
    .i_line_start (line_start),
    .i_pxl_valid  (pxl_valid),
    .o_accept     (w_accept),
    .o_col        (w_col),
    .o_row_end    (w_row_end),
    .o_frame_end  (w_frame_end),
    .o_row        (w_row)
  );

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  // FSM next state; a frame in progress always runs to its last bin row
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:       if (start_en) w_state_next = ST_WAIT_FRAME;
      ST_WAIT_FRAME: begin
        if (!start_en)        w_state_next = ST_IDLE;
        else if (frame_start) w_state_next = ST_ACTIVE;
      end
      ST_ACTIVE:     if (w_frame_end)
                       w_state_next = (cont_read && start_en) ? ST_WAIT_FRAME : ST_IDLE;
      default:       w_state_next = ST_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    pxl_idle_o = (r_state == ST_IDLE);
  end

  // Per-column next sums include the pixel of this cycle, so a commit can
  // store them directly while the working set is cleared
  for (genvar gi = 0; gi < COLS; gi++) begin : g_col
    logic w_hit;
    assign w_hit      = w_accept && (w_col == COL_W'(gi));
    assign w_sum_r[gi] = r_acc_r[gi] + (w_hit ? px_r(pxl_data) : 16'd0);
    assign w_sum_g[gi] = r_acc_g[gi] + (w_hit ? px_g(pxl_data) : 16'd0);
    assign w_sum_b[gi] = r_acc_b[gi] + (w_hit ? px_b(pxl_data) : 16'd0);
  end

  // Working accumulators, cleared on commit and on restart
  always_ff @(posedge clk or posedge reset) begin
    if (reset || 1'b0) begin
      r_acc_r <= '0;
      r_acc_g <= '0;
      r_acc_b <= '0;
    end else if (w_clr || w_row_end) begin
      r_acc_r <= '0;
      r_acc_g <= '0;
      r_acc_b <= '0;
    end else begin
      r_acc_r <= w_sum_r;
      r_acc_g <= w_sum_g;
      r_acc_b <= w_sum_b;
    end
  end

  // Bank commit, row index and row_done pulse; banks move only on commit
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bank_r   <= '0;
      r_bank_g   <= '0;
      r_bank_b   <= '0;
      r_row_o    <= '0;
      r_row_done <= 1'b0;
    end else begin
      r_row_done <= w_row_end;
      if (w_row_end) begin
        r_bank_r[w_row[0]] <= w_sum_r;
        r_bank_g[w_row[0]] <= w_sum_g;
        r_bank_b[w_row[0]] <= w_sum_b;
        r_row_o            <= 6'(w_row);
      end
    end
  end

  assign r_data   = r_bank_r;
  assign g_data   = r_bank_g;
  assign b_data   = r_bank_b;
  assign row_o    = r_row_o;
  assign row_done = r_row_done;

endmodule

// File: tb/tb_pxl_row_binner.sv
// Directed bench: a default-size binner (640x480, 32 bins) for single bin
// rows and a small one (16x8, 4 bins) for whole-frame behaviour.
module tb_pxl_row_binner;

  logic clk;

  // default-size instance
  logic d_reset, d_start_en, d_cont_read, d_frame_start, d_line_start, d_pxl_valid;
  logic [15:0] d_pxl_data;
  logic [1:0][31:0][15:0] d_r, d_g, d_b;
  logic [5:0] d_row;
  logic d_done, d_idle;

  // small instance: BIN_W = 4, BIN_H = 2
  logic s_reset, s_start_en, s_cont_read, s_frame_start, s_line_start, s_pxl_valid;
  logic [15:0] s_pxl_data;
  logic [1:0][3:0][15:0] s_r, s_g, s_b;
  logic [5:0] s_row;
  logic s_done, s_idle;

  int checks = 0;
  int errors = 0;
  int d_done_cnt = 0;
  int s_done_cnt = 0;

  pxl_row_binner dut (
    .clk(clk), .reset(d_reset), .start_en(d_start_en), .cont_read(d_cont_read),
    .frame_start(d_frame_start), .line_start(d_line_start), .pxl_valid(d_pxl_valid),
    .pxl_data(d_pxl_data), .r_data(d_r), .g_data(d_g), .b_data(d_b),
    .row_o(d_row), .row_done(d_done), .pxl_idle_o(d_idle)
  );

  pxl_row_binner #(.H_PIXELS(16), .V_LINES(8), .COLS(4)) dut_s (
    .clk(clk), .reset(s_reset), .start_en(s_start_en), .cont_read(s_cont_read),
    .frame_start(s_frame_start), .line_start(s_line_start), .pxl_valid(s_pxl_valid),
    .pxl_data(s_pxl_data), .r_data(s_r), .g_data(s_g), .b_data(s_b),
    .row_o(s_row), .row_done(s_done), .pxl_idle_o(s_idle)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // row_done pulse counters, sampled mid-cycle
  always @(negedge clk) begin
    if (d_done === 1'b1) d_done_cnt <= d_done_cnt + 1;
    if (s_done === 1'b1) s_done_cnt <= s_done_cnt + 1;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_frame(input bit sm);
    if (sm) s_frame_start = 1'b1; else d_frame_start = 1'b1;
    tick(1);
    s_frame_start = 1'b0;
    d_frame_start = 1'b0;
  endtask

  // One line of n pixels, back to back, line_start with pixel 0.
  // colmode puts the bin column index in R.
  task automatic drive_line(input bit sm, input int n, input logic [15:0] data, input bit colmode);
    int binw;
    logic [15:0] px;
    binw = sm ? 4 : 20;
    for (int i = 0; i < n; i++) begin
      px = colmode ? 16'((i / binw) << 11) : data;
      if (sm) begin
        s_line_start = (i == 0); s_pxl_valid = 1'b1; s_pxl_data = px;
      end else begin
        d_line_start = (i == 0); d_pxl_valid = 1'b1; d_pxl_data = px;
      end
      tick(1);
    end
    s_line_start = 1'b0; s_pxl_valid = 1'b0;
    d_line_start = 1'b0; d_pxl_valid = 1'b0;
  endtask

  task automatic test_reset();
    checks += 6;
    if (d_idle !== 1'b1) begin errors++; $display("FAIL reset_idle: got %0b expected 1", d_idle); end
    if (d_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %0b expected 0", d_done); end
    if (d_row !== 6'd0) begin errors++; $display("FAIL reset_row: got %0d expected 0", d_row); end
    if ((d_r | d_g | d_b) !== '0) begin errors++; $display("FAIL reset_banks: nonzero bank data, expected 0"); end
    if (s_idle !== 1'b1) begin errors++; $display("FAIL reset_s_idle: got %0b expected 1", s_idle); end
    if ((s_r | s_g | s_b) !== '0) begin errors++; $display("FAIL reset_s_banks: nonzero bank data, expected 0"); end
    $display("test_reset done");
  endtask

  task automatic test_full_white();
    int base;
    base = d_done_cnt;
    d_start_en = 1'b1;
    tick(1);
    pulse_frame(0);
    for (int l = 0; l < 15; l++) drive_line(0, 640, 16'hFFFF, 0);
    tick(3);
    checks += 4;
    if (d_done_cnt - base !== 1) begin errors++; $display("FAIL white_done_count: got %0d expected 1", d_done_cnt - base); end
    if (d_row !== 6'd0) begin errors++; $display("FAIL white_row: got %0d expected 0", d_row); end
    if (d_idle !== 1'b0) begin errors++; $display("FAIL white_active: idle %0b expected 0", d_idle); end
    if ((d_r[1] | d_g[1] | d_b[1]) !== '0) begin errors++; $display("FAIL white_bank1: bank1 changed, expected 0"); end
    for (int c = 0; c < 32; c++) begin
      checks++;
      if (d_r[0][c] !== 16'd9300 || d_g[0][c] !== 16'd18900 || d_b[0][c] !== 16'd9300) begin
        errors++;
        $display("FAIL white_sum col %0d: got R=%0d G=%0d B=%0d expected 9300/18900/9300",
                 c, d_r[0][c], d_g[0][c], d_b[0][c]);
      end
    end
    $display("test_full_white done: row_done=%0d", d_done_cnt - base);
  endtask

  task automatic test_long_lines();
    int base;
    base = d_done_cnt;
    pulse_frame(0);
    for (int l = 0; l < 15; l++) drive_line(0, 700, 16'h0821, 0);
    tick(3);
    checks += 2;
    if (d_done_cnt - base !== 1) begin errors++; $display("FAIL long_done_count: got %0d expected 1", d_done_cnt - base); end
    if (d_row !== 6'd0) begin errors++; $display("FAIL long_row: got %0d expected 0", d_row); end
    for (int c = 0; c < 32; c++) begin
      checks++;
      if (d_r[0][c] !== 16'd300 || d_g[0][c] !== 16'd300 || d_b[0][c] !== 16'd300) begin
        errors++;
        $display("FAIL long_sum col %0d: got R=%0d G=%0d B=%0d expected 300/300/300",
                 c, d_r[0][c], d_g[0][c], d_b[0][c]);
      end
    end
    $display("test_long_lines done: row_done=%0d", d_done_cnt - base);
  endtask

  task automatic test_frame_restart();
    int base;
    base = d_done_cnt;
    pulse_frame(0);
    for (int l = 0; l < 7; l++) drive_line(0, 640, 16'hFFFF, 0);
    pulse_frame(0);
    tick(2);
    checks += 2;
    if (d_done_cnt - base !== 0) begin errors++; $display("FAIL restart_no_done: got %0d expected 0", d_done_cnt - base); end
    if (d_r[0][0] !== 16'd300) begin errors++; $display("FAIL restart_bank_hold: got %0d expected 300", d_r[0][0]); end
    for (int l = 0; l < 15; l++) drive_line(0, 640, 16'h1082, 0);
    tick(3);
    checks += 2;
    if (d_done_cnt - base !== 1) begin errors++; $display("FAIL restart_done_count: got %0d expected 1", d_done_cnt - base); end
    if (d_row !== 6'd0) begin errors++; $display("FAIL restart_row: got %0d expected 0", d_row); end
    for (int c = 0; c < 32; c++) begin
      checks++;
      if (d_r[0][c] !== 16'd600 || d_g[0][c] !== 16'd1200 || d_b[0][c] !== 16'd600) begin
        errors++;
        $display("FAIL restart_sum col %0d: got R=%0d G=%0d B=%0d expected 600/1200/600",
                 c, d_r[0][c], d_g[0][c], d_b[0][c]);
      end
    end
    $display("test_frame_restart done: row_done=%0d", d_done_cnt - base);
  endtask

  task automatic test_reset_midline();
    pulse_frame(0);
    drive_line(0, 300, 16'hFFFF, 0);
    d_reset = 1'b1;
    #1;
    checks += 3;
    if (d_idle !== 1'b1) begin errors++; $display("FAIL midline_idle: got %0b expected 1", d_idle); end
    if (d_done !== 1'b0) begin errors++; $display("FAIL midline_done: got %0b expected 0", d_done); end
    if ((d_r | d_g | d_b) !== '0) begin errors++; $display("FAIL midline_banks: nonzero bank data, expected 0"); end
    tick(2);
    d_reset = 1'b0;
    d_start_en = 1'b0;
    $display("test_reset_midline done");
  endtask

  task automatic test_col_index();
    int base;
    base = s_done_cnt;
    s_start_en = 1'b1;
    s_cont_read = 1'b0;
    tick(1);
    pulse_frame(1);
    drive_line(1, 16, 16'h0000, 1);
    s_start_en = 1'b0;
    for (int l = 1; l < 8; l++) drive_line(1, 16, 16'h0000, 1);
    tick(3);
    checks += 3;
    if (s_done_cnt - base !== 4) begin errors++; $display("FAIL col_done_count: got %0d expected 4", s_done_cnt - base); end
    if (s_row !== 6'd3) begin errors++; $display("FAIL col_row: got %0d expected 3", s_row); end
    if (s_idle !== 1'b1) begin errors++; $display("FAIL col_idle: got %0b expected 1", s_idle); end
    for (int c = 0; c < 4; c++) begin
      checks += 2;
      if (s_r[1][c] !== 16'(8 * c) || s_g[1][c] !== 16'd0 || s_b[1][c] !== 16'd0) begin
        errors++;
        $display("FAIL col_bank1 col %0d: got R=%0d G=%0d B=%0d expected %0d/0/0",
                 c, s_r[1][c], s_g[1][c], s_b[1][c], 8 * c);
      end
      if (s_r[0][c] !== 16'(8 * c)) begin
        errors++;
        $display("FAIL col_bank0 col %0d: got R=%0d expected %0d", c, s_r[0][c], 8 * c);
      end
    end
    $display("test_col_index done: row_done=%0d", s_done_cnt - base);
  endtask

  task automatic test_cont_read();
    int base;
    base = s_done_cnt;
    s_start_en = 1'b1;
    s_cont_read = 1'b1;
    tick(1);
    pulse_frame(1);
    for (int l = 0; l < 8; l++) drive_line(1, 16, 16'h0821, 0);
    tick(2);
    pulse_frame(1);
    for (int l = 0; l < 8; l++) drive_line(1, 16, 16'h0821, 0);
    tick(3);
    checks += 3;
    if (s_done_cnt - base !== 8) begin errors++; $display("FAIL cont_done_count: got %0d expected 8", s_done_cnt - base); end
    if (s_idle !== 1'b0) begin errors++; $display("FAIL cont_wait_frame: idle %0b expected 0", s_idle); end
    if (s_row !== 6'd3) begin errors++; $display("FAIL cont_row: got %0d expected 3", s_row); end
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (s_r[0][c] !== 16'd8 || s_g[0][c] !== 16'd8 || s_b[1][c] !== 16'd8) begin
        errors++;
        $display("FAIL cont_sum col %0d: got R0=%0d G0=%0d B1=%0d expected 8", c, s_r[0][c], s_g[0][c], s_b[1][c]);
      end
    end
    // pixels in WAIT_FRAME must not produce commits
    for (int l = 0; l < 8; l++) drive_line(1, 16, 16'hFFFF, 0);
    tick(2);
    checks += 2;
    if (s_done_cnt - base !== 8) begin errors++; $display("FAIL cont_wait_ignore: got %0d expected 8", s_done_cnt - base); end
    if (s_r[0][0] !== 16'd8) begin errors++; $display("FAIL cont_wait_bank: got %0d expected 8", s_r[0][0]); end
    $display("test_cont_read done: row_done=%0d", s_done_cnt - base);
  endtask

  task automatic test_reset_midframe();
    int base;
    s_cont_read = 1'b0;
    pulse_frame(1);
    for (int l = 0; l < 5; l++) drive_line(1, 16, 16'hFFFF, 0);
    drive_line(1, 6, 16'hFFFF, 0);
    checks++;
    if (s_row !== 6'd1) begin errors++; $display("FAIL midframe_pre_row: got %0d expected 1", s_row); end
    s_reset = 1'b1;
    #1;
    checks += 4;
    if (s_idle !== 1'b1) begin errors++; $display("FAIL midframe_idle: got %0b expected 1", s_idle); end
    if (s_done !== 1'b0) begin errors++; $display("FAIL midframe_done: got %0b expected 0", s_done); end
    if (s_row !== 6'd0) begin errors++; $display("FAIL midframe_row: got %0d expected 0", s_row); end
    if ((s_r | s_g | s_b) !== '0) begin errors++; $display("FAIL midframe_banks: nonzero bank data, expected 0"); end
    tick(2);
    s_reset = 1'b0;
    base = s_done_cnt;
    tick(1);
    pulse_frame(1);
    for (int l = 0; l < 2; l++) drive_line(1, 16, 16'h0821, 0);
    tick(3);
    checks += 4;
    if (s_done_cnt - base !== 1) begin errors++; $display("FAIL after_reset_done: got %0d expected 1", s_done_cnt - base); end
    if (s_row !== 6'd0) begin errors++; $display("FAIL after_reset_row: got %0d expected 0", s_row); end
    if (s_r[0][0] !== 16'd8) begin errors++; $display("FAIL after_reset_sum: got %0d expected 8", s_r[0][0]); end
    if (s_r[1] !== '0) begin errors++; $display("FAIL after_reset_bank1: bank1 nonzero, expected 0"); end
    $display("test_reset_midframe done: row_done=%0d", s_done_cnt - base);
  endtask

  initial begin
    d_reset = 1'b1; d_start_en = 1'b0; d_cont_read = 1'b0; d_frame_start = 1'b0;
    d_line_start = 1'b0; d_pxl_valid = 1'b0; d_pxl_data = 16'h0000;
    s_reset = 1'b1; s_start_en = 1'b0; s_cont_read = 1'b0; s_frame_start = 1'b0;
    s_line_start = 1'b0; s_pxl_valid = 1'b0; s_pxl_data = 16'h0000;
    tick(2);
    d_reset = 1'b0;
    s_reset = 1'b0;
    tick(1);
    test_reset();
    test_full_white();
    test_long_lines();
    test_frame_restart();
    test_reset_midline();
    test_col_index();
    test_cont_read();
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
